// File: rtl/ov7670_rgb444_capture.sv
// OV7670 RGB444 frame capture: arms on request, waits for a VSYNC blanking pulse,
// then assembles two-byte pixels into 12-bit RGB with column/line coordinates.
module ov7670_rgb444_capture #(
  parameter int H_PIXELS   = 320,
  parameter int V_LINES    = 240,
  parameter bit CONTINUOUS = 1'b0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        arm,
  input  logic                        cam_vsync,
  input  logic                        cam_href,
  input  logic [7:0]                  cam_data,
  output logic [11:0]                 rgb,
  output logic                        pixel_valid,
  output logic [$clog2(H_PIXELS)-1:0] x,
  output logic [$clog2(V_LINES)-1:0]  y,
  output logic                        frame_start,
  output logic                        frame_done,
  output logic                        frame_abort,
  output logic                        busy,
  output logic                        err
);

  localparam int XW = $clog2(H_PIXELS);
  localparam int YW = $clog2(V_LINES);
  localparam int CW = $clog2(H_PIXELS + 1);

  localparam logic [CW-1:0] COL_FULL  = CW'(H_PIXELS);
  localparam logic [CW-1:0] COL_ONE   = CW'(1);
  localparam logic [YW-1:0] LAST_LINE = YW'(V_LINES - 1);
  localparam logic [YW-1:0] LINE_ONE  = YW'(1);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_VS,
    WAIT_FRAME,
    ACTIVE,
    DONE
  } state_e;

  state_e          state_q, state_d;
  logic            phase_q, phase_d;
  logic [3:0]      red_q, red_d;
  logic [CW-1:0]   col_q, col_d;
  logic [YW-1:0]   line_q, line_d;
  logic            href_prev_q, href_prev_d;

  logic [11:0]     rgb_q, rgb_d;
  logic            pixel_valid_q, pixel_valid_d;
  logic [XW-1:0]   x_q, x_d;
  logic [YW-1:0]   y_q, y_d;
  logic            frame_start_q, frame_start_d;
  logic            frame_done_q, frame_done_d;
  logic            frame_abort_q, frame_abort_d;
  logic            busy_q, busy_d;
  logic            err_q, err_d;

  logic            href_fall;
  logic            last_line;

  assign href_fall = href_prev_q & ~cam_href;
  assign last_line = (line_q == LAST_LINE);

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; an incomplete assignment in always_comb would infer a latch.
    state_d       = state_q;
    phase_d       = phase_q;
    red_d         = red_q;
    col_d         = col_q;
    line_d        = line_q;
    href_prev_d   = 1'b0;
    rgb_d         = rgb_q;
    pixel_valid_d = 1'b0;
    x_d           = x_q;
    y_d           = y_q;
    frame_start_d = 1'b0;
    frame_done_d  = 1'b0;
    frame_abort_d = 1'b0;
    err_d         = err_q;

    unique case (state_q)
      IDLE: begin
        if (arm) begin
          state_d = WAIT_VS;
          err_d   = 1'b0;
        end
      end

      WAIT_VS: begin
        if (cam_vsync) state_d = WAIT_FRAME;
      end

      WAIT_FRAME: begin
        if (!cam_vsync) begin
          state_d       = ACTIVE;
          frame_start_d = 1'b1;
          col_d         = '0;
          line_d        = '0;
          phase_d       = 1'b0;
          x_d           = '0;
          y_d           = '0;
        end
      end

      ACTIVE: begin
        href_prev_d = cam_href;

        if (cam_href) begin
          phase_d = ~phase_q;
          if (!phase_q) begin
            red_d = cam_data[3:0];
          end else if (col_q != COL_FULL) begin
            rgb_d         = {red_q, cam_data};
            pixel_valid_d = 1'b1;
            x_d           = col_q[XW-1:0];
            y_d           = line_q;
            col_d         = col_q + COL_ONE;
          end else begin
            err_d = 1'b1;  // pixel past the end of the line is dropped
          end
        end

        if (href_fall) begin
          col_d  = '0;
          line_d = line_q + LINE_ONE;
          if (col_q != COL_FULL) err_d = 1'b1;
          if (phase_q) begin
            phase_d = 1'b0;
            err_d   = 1'b1;
          end
          if (last_line) begin
            state_d      = DONE;
            line_d       = '0;
            frame_done_d = 1'b1;
          end
        end

        // A completed last line wins over a simultaneous VSYNC rise.
        if (cam_vsync && !(href_fall && last_line)) begin
          frame_abort_d = 1'b1;
          err_d         = 1'b1;
          phase_d       = 1'b0;
          pixel_valid_d = 1'b0;
          rgb_d         = rgb_q;
          x_d           = x_q;
          y_d           = y_q;
          state_d       = CONTINUOUS ? WAIT_FRAME : IDLE;
        end
      end

      DONE: begin
        state_d = CONTINUOUS ? WAIT_VS : IDLE;
      end

      default: state_d = IDLE;
    endcase

    busy_d = (state_d == WAIT_VS) || (state_d == WAIT_FRAME) || (state_d == ACTIVE);
  end

  // NOTE: all state updates use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      phase_q       <= 1'b0;
      red_q         <= '0;
      col_q         <= '0;
      line_q        <= '0;
      href_prev_q   <= 1'b0;
      rgb_q         <= '0;
      pixel_valid_q <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      frame_start_q <= 1'b0;
      frame_done_q  <= 1'b0;
      frame_abort_q <= 1'b0;
      busy_q        <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      phase_q       <= phase_d;
      red_q         <= red_d;
      col_q         <= col_d;
      line_q        <= line_d;
      href_prev_q   <= href_prev_d;
      rgb_q         <= rgb_d;
      pixel_valid_q <= pixel_valid_d;
      x_q           <= x_d;
      y_q           <= y_d;
      frame_start_q <= frame_start_d;
      frame_done_q  <= frame_done_d;
      frame_abort_q <= frame_abort_d;
      busy_q        <= busy_d;
      err_q         <= err_d;
    end
  end

  assign rgb         = rgb_q;
  assign pixel_valid = pixel_valid_q;
  assign x           = x_q;
  assign y           = y_q;
  assign frame_start = frame_start_q;
  assign frame_done  = frame_done_q;
  assign frame_abort = frame_abort_q;
  assign busy        = busy_q;
  assign err         = err_q;

endmodule

// File: tb/tb_ov7670_rgb444_capture.sv
// Randomized bench: two capture instances (single-shot and continuous) fed from a
// shared camera model; expected pixels come from a byte-pair reference model.
module tb_ov7670_rgb444_capture;

  localparam int H = 4;
  localparam int V = 2;

  typedef struct {
    logic [11:0] rgb;
    int          x;
    int          y;
  } pix_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       arm0, arm1;
  logic       cam_vsync, cam_href;
  logic [7:0] cam_data;

  logic [11:0]          rgb0, rgb1;
  logic                 pv0, pv1;
  logic [$clog2(H)-1:0] x0, x1;
  logic [$clog2(V)-1:0] y0, y1;
  logic                 fs0, fs1, fd0, fd1, fa0, fa1, busy0, busy1, err0, err1;

  int n_checks = 0;
  int n_errors = 0;

  pix_t exp0[$];
  pix_t exp1[$];
  bit   exp_err0;

  int n_pv0 = 0, n_fs0 = 0, n_fd0 = 0, n_fa0 = 0;
  int n_pv1 = 0, n_fs1 = 0, n_fd1 = 0, n_fa1 = 0;
  logic pv0_prev = 1'b0, pv1_prev = 1'b0;

  always #5 clk = ~clk;

  ov7670_rgb444_capture #(.H_PIXELS(H), .V_LINES(V), .CONTINUOUS(0)) dut0 (
    .clk(clk), .rst(rst), .arm(arm0), .cam_vsync(cam_vsync), .cam_href(cam_href),
    .cam_data(cam_data), .rgb(rgb0), .pixel_valid(pv0), .x(x0), .y(y0),
    .frame_start(fs0), .frame_done(fd0), .frame_abort(fa0), .busy(busy0), .err(err0)
  );

  ov7670_rgb444_capture #(.H_PIXELS(H), .V_LINES(V), .CONTINUOUS(1)) dut1 (
    .clk(clk), .rst(rst), .arm(arm1), .cam_vsync(cam_vsync), .cam_href(cam_href),
    .cam_data(cam_data), .rgb(rgb1), .pixel_valid(pv1), .x(x1), .y(y1),
    .frame_start(fs1), .frame_done(fd1), .frame_abort(fa1), .busy(busy1), .err(err1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Output monitor: scores every emitted pixel against the model queues.
  always @(negedge clk) begin
    pix_t e;
    if (pv0) begin
      check("pv0_spacing", 32'(pv0_prev), 32'd0);
      n_pv0++;
      if (exp0.size() == 0) begin
        check("pix0_unexpected", 32'd1, 32'd0);
      end else begin
        e = exp0.pop_front();
        check("pix0_rgb", 32'(rgb0), 32'(e.rgb));
        check("pix0_x", 32'(x0), 32'(e.x));
        check("pix0_y", 32'(y0), 32'(e.y));
      end
    end
    if (pv1) begin
      check("pv1_spacing", 32'(pv1_prev), 32'd0);
      n_pv1++;
      if (exp1.size() == 0) begin
        check("pix1_unexpected", 32'd1, 32'd0);
      end else begin
        e = exp1.pop_front();
        check("pix1_rgb", 32'(rgb1), 32'(e.rgb));
        check("pix1_x", 32'(x1), 32'(e.x));
        check("pix1_y", 32'(y1), 32'(e.y));
      end
    end
    if (fs0) n_fs0++;
    if (fd0) n_fd0++;
    if (fa0) n_fa0++;
    if (fs1) n_fs1++;
    if (fd1) n_fd1++;
    if (fa1) n_fa1++;
    pv0_prev = pv0;
    pv1_prev = pv1;
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic vsync_pulse();
    @(posedge clk); #1 cam_vsync = 1'b1;
    idle(3);
    cam_vsync = 1'b0;
    idle(2);
  endtask

  task automatic start_frame(input int which);
    @(posedge clk); #1;
    if (which == 0) begin arm0 = 1'b1; exp_err0 = 1'b0; end
    else arm1 = 1'b1;
    @(posedge clk); #1;
    arm0 = 1'b0;
    arm1 = 1'b0;
    vsync_pulse();
  endtask

  // Reference model: byte pairs form {lo nibble of byte0, byte1}; only the
  // first H pairs of a line are kept; any line that is not exactly 2*H bytes
  // is a protocol error.
  task automatic send_line(input int which, input int nbytes, input int line_idx,
                           input bit fixed, input bit vs_at_end);
    logic [7:0] bytes[$];
    logic [7:0] b0, b1;
    pix_t       p;
    for (int i = 0; i < nbytes; i++)
      bytes.push_back(fixed ? ((i % 2 == 1) ? 8'h5C : 8'h0A) : 8'($urandom));
    for (int k = 0; k < nbytes / 2; k++) begin
      if (k < H) begin
        b0    = bytes[2*k];
        b1    = bytes[2*k+1];
        p.rgb = {b0[3:0], b1};
        p.x   = k;
        p.y   = line_idx;
        if (which == 0) exp0.push_back(p);
        else exp1.push_back(p);
      end
    end
    if (which == 0 && nbytes != 2 * H) exp_err0 = 1'b1;
    for (int i = 0; i < nbytes; i++) begin
      @(posedge clk); #1;
      cam_href = 1'b1;
      cam_data = bytes[i];
    end
    @(posedge clk); #1;
    cam_href = 1'b0;
    cam_data = 8'h00;
    if (vs_at_end) cam_vsync = 1'b1;
    idle($urandom_range(2, 4));
    cam_vsync = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rgb0"}, 32'(rgb0), 32'd0);
    check({tag, "_pv0"}, 32'(pv0), 32'd0);
    check({tag, "_x0"}, 32'(x0), 32'd0);
    check({tag, "_y0"}, 32'(y0), 32'd0);
    check({tag, "_flags0"}, {27'd0, fs0, fd0, fa0, busy0, err0}, 32'd0);
    check({tag, "_flags1"}, {27'd0, fs1, fd1, fa1, busy1, err1}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s_fs, s_fd, s_fa, s_pv;
    rst = 1'b1; arm0 = 1'b0; arm1 = 1'b0;
    cam_vsync = 1'b0; cam_href = 1'b0; cam_data = 8'h00;
    exp_err0 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    #1 rst = 1'b0;
    idle(2);

    // Fixed-pattern clean frame.
    s_fs = n_fs0; s_fd = n_fd0; s_fa = n_fa0; s_pv = n_pv0;
    start_frame(0);
    check("s1_busy_mid", 32'(busy0), 32'd1);
    for (int l = 0; l < V; l++) send_line(0, 2 * H, l, 1'b1, 1'b0);
    idle(3);
    check("s1_start", 32'(n_fs0 - s_fs), 32'd1);
    check("s1_done", 32'(n_fd0 - s_fd), 32'd1);
    check("s1_abort", 32'(n_fa0 - s_fa), 32'd0);
    check("s1_pixels", 32'(n_pv0 - s_pv), 32'(H * V));
    check("s1_err", 32'(err0), 32'd0);
    check("s1_busy_end", 32'(busy0), 32'd0);

    // Odd-length line, then over-long line.
    s_fd = n_fd0; s_pv = n_pv0;
    start_frame(0);
    send_line(0, 2 * H - 1, 0, 1'b0, 1'b0);
    send_line(0, 2 * H, 1, 1'b0, 1'b0);
    idle(3);
    check("odd_done", 32'(n_fd0 - s_fd), 32'd1);
    check("odd_pixels", 32'(n_pv0 - s_pv), 32'(H - 1 + H));
    check("odd_err", 32'(err0), 32'(exp_err0));

    s_fd = n_fd0; s_pv = n_pv0;
    start_frame(0);
    send_line(0, 2 * H + 2, 0, 1'b0, 1'b0);
    send_line(0, 2 * H, 1, 1'b0, 1'b0);
    idle(3);
    check("long_done", 32'(n_fd0 - s_fd), 32'd1);
    check("long_pixels", 32'(n_pv0 - s_pv), 32'(2 * H));
    check("long_err", 32'(err0), 32'(exp_err0));

    // VSYNC rising after line 0 aborts the frame.
    s_fd = n_fd0; s_fa = n_fa0;
    start_frame(0);
    send_line(0, 2 * H, 0, 1'b0, 1'b0);
    vsync_pulse();
    idle(2);
    check("abort_pulse", 32'(n_fa0 - s_fa), 32'd1);
    check("abort_no_done", 32'(n_fd0 - s_fd), 32'd0);
    check("abort_err", 32'(err0), 32'd1);
    check("abort_idle", 32'(busy0), 32'd0);
    check("abort_queue", 32'(exp0.size()), 32'd0);

    // VSYNC rising with the final HREF fall: the frame completes.
    s_fd = n_fd0; s_fa = n_fa0;
    start_frame(0);
    send_line(0, 2 * H, 0, 1'b0, 1'b0);
    send_line(0, 2 * H, 1, 1'b0, 1'b1);
    idle(3);
    check("lastvs_done", 32'(n_fd0 - s_fd), 32'd1);
    check("lastvs_abort", 32'(n_fa0 - s_fa), 32'd0);
    check("lastvs_err", 32'(err0), 32'd0);

    // Reset in the middle of a line.
    begin
      logic [7:0] b0, b1;
      pix_t       p;
      start_frame(0);
      b0 = 8'($urandom); b1 = 8'($urandom);
      p.rgb = {b0[3:0], b1}; p.x = 0; p.y = 0;
      exp0.push_back(p);
      @(posedge clk); #1 cam_href = 1'b1; cam_data = b0;
      @(posedge clk); #1 cam_data = b1;
      @(posedge clk); #1 cam_data = 8'($urandom);
      @(negedge clk);
      check("rst_busy_before", 32'(busy0), 32'd1);
      @(posedge clk); #1 cam_data = 8'($urandom); rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check_all_zero("midrst");
      #1 rst = 1'b0; cam_href = 1'b0; cam_data = 8'h00;
      idle(2);
      check("midrst_queue", 32'(exp0.size()), 32'd0);
    end
    s_fd = n_fd0; s_pv = n_pv0;
    start_frame(0);
    for (int l = 0; l < V; l++) send_line(0, 2 * H, l, 1'b0, 1'b0);
    idle(3);
    check("postrst_done", 32'(n_fd0 - s_fd), 32'd1);
    check("postrst_pixels", 32'(n_pv0 - s_pv), 32'(H * V));
    check("postrst_err", 32'(err0), 32'd0);

    // Random line lengths.
    for (int f = 0; f < 6; f++) begin
      s_fd = n_fd0;
      start_frame(0);
      for (int l = 0; l < V; l++) send_line(0, $urandom_range(2 * H - 3, 2 * H + 3), l, 1'b0, 1'b0);
      idle(3);
      check("rnd_done", 32'(n_fd0 - s_fd), 32'd1);
      check("rnd_err", 32'(err0), 32'(exp_err0));
      check("rnd_queue", 32'(exp0.size()), 32'd0);
      check("rnd_busy", 32'(busy0), 32'd0);
    end

    // Continuous instance: one arm, two back-to-back frames.
    check("cont_idle_pixels", 32'(n_pv1), 32'd0);
    s_pv = n_pv0;
    start_frame(1);
    for (int l = 0; l < V; l++) send_line(1, 2 * H, l, 1'b0, 1'b0);
    vsync_pulse();
    for (int l = 0; l < V; l++) send_line(1, 2 * H, l, 1'b0, 1'b0);
    idle(3);
    check("cont_starts", 32'(n_fs1), 32'd2);
    check("cont_dones", 32'(n_fd1), 32'd2);
    check("cont_aborts", 32'(n_fa1), 32'd0);
    check("cont_pixels", 32'(n_pv1), 32'(2 * H * V));
    check("cont_err", 32'(err1), 32'd0);
    check("cont_rearmed", 32'(busy1), 32'd1);
    check("cont_queue", 32'(exp1.size()), 32'd0);
    check("unarmed_ignores", 32'(n_pv0 - s_pv), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ov7670_rgb444_capture.md
OV7670_RGB444_CAPTURE -- requirements
Module: ov7670_rgb444_capture

Interface
REQ-001 SHALL have parameter H_PIXELS, default 320: pixels per active line.
REQ-002 SHALL have parameter V_LINES, default 240: active lines per frame.
REQ-003 SHALL have parameter CONTINUOUS, default 0: 1 = re-arm automatically after each frame.
REQ-004 SHALL have ports:
- clk  in  1  camera pixel clock; the only clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- arm  in  1  one-cycle request to capture the next frame.
- cam_vsync  in  1  OV7670 VSYNC; high = vertical blanking.
- cam_href  in  1  OV7670 HREF; high = valid byte on cam_data.
- cam_data  in  8  OV7670 data byte.
- rgb  out  12  assembled pixel {R[3:0],G[3:0],B[3:0]}.
- pixel_valid  out  1  rgb valid this cycle; drives the encoder en.
- x  out  $clog2(H_PIXELS)  column of the current rgb.
- y  out  $clog2(V_LINES)  line of the current rgb.
- frame_start  out  1  one-cycle pulse at the start of a captured frame.
- frame_done  out  1  one-cycle pulse after the last pixel of a complete frame.
- frame_abort  out  1  one-cycle pulse when a frame ends early.
- busy  out  1  high in WAIT_VS, WAIT_FRAME and ACTIVE.
- err  out  1  sticky protocol error; cleared by rst or arm.

Function
REQ-005 The FSM SHALL have the states IDLE, WAIT_VS, WAIT_FRAME, ACTIVE and DONE.
REQ-006 In IDLE, arm SHALL go to WAIT_VS and clear err; arm SHALL be ignored in every other state.
REQ-007 In WAIT_VS, cam_vsync=1 SHALL go to WAIT_FRAME.
REQ-008 In WAIT_FRAME, cam_vsync=0 SHALL go to ACTIVE, pulse frame_start the same cycle, clear x, y and the byte phase.
REQ-009 In ACTIVE, each cycle with cam_href=1 SHALL toggle the byte phase.
- Phase 0: latch cam_data[3:0] as R (upper nibble discarded).
- Phase 1: register rgb={R,cam_data[7:4],cam_data[3:0]} with pixel_valid=1 for exactly the next cycle.
REQ-010 Latency: pixel_valid SHALL be high in the cycle immediately after the edge that samples the second byte; x and y SHALL be registered with rgb.
REQ-011 x SHALL increment after each emitted pixel.
REQ-012 Pixels beyond H_PIXELS-1 in a line SHALL be dropped (no pixel_valid) and SHALL set err.
REQ-013 On a cam_href falling edge (sampled 1 then 0):
- x SHALL clear to 0 and y SHALL increment.
- If the line held fewer than H_PIXELS pixels, err SHALL be set.
- If the byte phase was 1 (odd byte count), the phase SHALL reset to 0, the half pixel SHALL be discarded and err SHALL be set.
REQ-014 When the cam_href falling edge completes line V_LINES-1, the FSM SHALL go to DONE.
REQ-015 DONE SHALL pulse frame_done for one cycle, then go to WAIT_VS if CONTINUOUS=1, else to IDLE.
REQ-016 cam_vsync=1 in ACTIVE before DONE SHALL:
- pulse frame_abort;
- set err;
- go to WAIT_FRAME (CONTINUOUS=1) or IDLE (CONTINUOUS=0);
- discard any half pixel.
REQ-017 cam_href falling edge and cam_vsync rising in the same cycle SHALL be treated as an abort unless that edge completes the last line, in which case DONE takes priority.
REQ-018 No pixel_valid SHALL occur outside ACTIVE, and cam_href activity outside ACTIVE SHALL be ignored.
REQ-019 pixel_valid SHALL never be high on two consecutive cycles.
REQ-020 Each complete frame SHALL produce exactly H_PIXELS*V_LINES pixel_valid cycles.

Reset
REQ-021 rst=1 at any clock edge, including mid-frame, SHALL force:
- FSM to IDLE, byte phase to 0;
- rgb, x, y to 0;
- pixel_valid, frame_start, frame_done, frame_abort, busy, err to 0.
REQ-022 rst SHALL take priority over all other inputs in the same cycle.

Verification
REQ-023 Bench SHALL use H_PIXELS=4, V_LINES=2 and cover these scenarios:
- arm, vsync pulse, 2 lines of 8 bytes 0x0A,0x5C repeated -> frame_start once; 8 pixel_valid with rgb=0xA5C, x 0..3 per line, y 0..1; frame_done once; err=0; busy returns 0.
- Line of 7 bytes (odd) -> 3 pixels, err=1; the frame completes with frame_done.
- Line of 10 bytes -> 4 pixels, 5th dropped, err=1.
- vsync rises after line 0 -> frame_abort pulse, no frame_done; with CONTINUOUS=0 the FSM is in IDLE.
- CONTINUOUS=1, two back-to-back frames, single arm -> two frame_start/frame_done pairs.
- rst mid-line (after byte 3) -> all outputs 0 next cycle; a subsequent arm captures a clean frame with rgb correct from the first pixel.
